// File: rtl/t9990_timing.sv
// t9990_timing
// Horizontal/vertical timing generator for the tiny9990 video path.
// Counts dots and lines on qualified dot-clock enables and decodes sync,
// display-enable and frame/line strobes for the pixel pipeline and the
// interrupt logic.
//
// Ports:
//   CLK          in   system clock
//   RESET        in   synchronous reset, active high
//   DCLK_EN      in   dot-clock enable, one CLK-wide pulse per dot
//   TG_EN        in   timing-generator enable, low while the dot clock re-syncs
//   RESO [2:0]   in   resolution code (B1..B4 supported, B5/B6 held off)
//   HCNT [9:0]   out  dot counter within the line
//   VCNT [8:0]   out  line counter within the frame
//   HSYNC_n      out  horizontal sync, active low
//   VSYNC_n      out  vertical sync, active low
//   DISP_EN      out  high inside the active area
//   LINE_START   out  one-CLK pulse when HCNT becomes 0
//   FRAME_START  out  one-CLK pulse when HCNT/VCNT become 0/0
//   VBLANK_START out  one-CLK pulse when HCNT/VCNT become 0/V_ACTIVE
module t9990_timing #(
  parameter int unsigned V_TOTAL  = 262,
  parameter int unsigned V_ACTIVE = 212,
  parameter int unsigned VS_START = 234,
  parameter int unsigned VS_WIDTH = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DCLK_EN,
  input  logic       TG_EN,
  input  logic [2:0] RESO,
  output logic [9:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HSYNC_n,
  output logic       VSYNC_n,
  output logic       DISP_EN,
  output logic       LINE_START,
  output logic       FRAME_START,
  output logic       VBLANK_START
);

  localparam logic [2:0] RESO_B1 = 3'd0;
  localparam logic [2:0] RESO_B2 = 3'd1;
  localparam logic [2:0] RESO_B3 = 3'd2;
  localparam logic [2:0] RESO_B4 = 3'd3;

  localparam logic [8:0] V_LAST_C   = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACTIVE_C = 9'(V_ACTIVE);
  localparam logic [8:0] VS_START_C = 9'(VS_START);
  localparam logic [8:0] VS_END_C   = 9'(VS_START + VS_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Horizontal geometry; last = H_TOTAL-1, hs_end = HS_START+HS_WIDTH.
  typedef struct packed {
    logic [9:0] last;
    logic [9:0] active;
    logic [9:0] hs_start;
    logic [9:0] hs_end;
  } h_timing_t;

  function automatic h_timing_t h_timing(input logic [2:0] mode);
    h_timing_t t;
    case (mode)
      RESO_B1: t = '{last: 10'd341, active: 10'd256, hs_start: 10'd270, hs_end: 10'd295};
      RESO_B2: t = '{last: 10'd454, active: 10'd384, hs_start: 10'd405, hs_end: 10'd438};
      RESO_B3: t = '{last: 10'd683, active: 10'd512, hs_start: 10'd540, hs_end: 10'd590};
      RESO_B4: t = '{last: 10'd909, active: 10'd768, hs_start: 10'd810, hs_end: 10'd877};
      default: t = '{last: 10'd341, active: 10'd256, hs_start: 10'd270, hs_end: 10'd295};
    endcase
    return t;
  endfunction

  function automatic logic reso_supported(input logic [2:0] reso);
    logic ok;
    case (reso)
      RESO_B1, RESO_B2, RESO_B3, RESO_B4: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t     state_r, state_s;
  logic [2:0] mode_r, mode_s;
  logic       started_r, started_s;
  logic [9:0] hcnt_r, hcnt_s;
  logic [8:0] vcnt_r, vcnt_s;
  logic       hsync_n_r, hsync_n_s;
  logic       vsync_n_r, vsync_n_s;
  logic       disp_r, disp_s;
  logic       line_r, line_s;
  logic       frame_r, frame_s;
  logic       vblank_r, vblank_s;
  h_timing_t  timing_s;

  // Next-state, next-counter and output decode from the next counter value.
  always_comb begin
    state_s   = state_r;
    mode_s    = mode_r;
    started_s = started_r;
    hcnt_s    = hcnt_r;
    vcnt_s    = vcnt_r;
    line_s    = 1'b0;
    frame_s   = 1'b0;
    vblank_s  = 1'b0;
    timing_s  = h_timing(mode_r);

    if (!TG_EN) begin
      // Dot clock is re-syncing: drop everything, even mid-frame.
      state_s   = ST_IDLE;
      started_s = 1'b0;
      hcnt_s    = 10'd0;
      vcnt_s    = 9'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          started_s = 1'b0;
          hcnt_s    = 10'd0;
          vcnt_s    = 9'd0;
          mode_s    = RESO;
          if (reso_supported(RESO)) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_HOLD: begin
          started_s = 1'b0;
          hcnt_s    = 10'd0;
          vcnt_s    = 9'd0;
          mode_s    = RESO;
          if (reso_supported(RESO)) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_RUN: begin
          if (DCLK_EN) begin
            if (!started_r) begin
              // First dot after entering RUN is the frame origin itself.
              started_s = 1'b1;
              hcnt_s    = 10'd0;
              vcnt_s    = 9'd0;
              line_s    = 1'b1;
              frame_s   = 1'b1;
            end else if (hcnt_r == timing_s.last) begin
              hcnt_s = 10'd0;
              line_s = 1'b1;
              if (vcnt_r == V_LAST_C) begin
                // Frame wrap: the only point where a new RESO takes effect.
                vcnt_s = 9'd0;
                mode_s = RESO;
                if (reso_supported(RESO)) begin
                  frame_s = 1'b1;
                end else begin
                  state_s   = ST_HOLD;
                  started_s = 1'b0;
                  line_s    = 1'b0;
                end
              end else begin
                vcnt_s   = vcnt_r + 9'd1;
                vblank_s = ((vcnt_r + 9'd1) == V_ACTIVE_C);
              end
            end else begin
              hcnt_s = hcnt_r + 10'd1;
            end
          end else begin
            hcnt_s = hcnt_r;
            vcnt_s = vcnt_r;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          started_s = 1'b0;
          hcnt_s    = 10'd0;
          vcnt_s    = 9'd0;
        end
      endcase
    end

    // Decode uses the pre-wrap mode even on the wrap dot; at HCNT=0 every
    // mode decodes identically, so the new table is in force from HCNT=0.
    if ((state_s == ST_RUN) && started_s) begin
      disp_s    = (hcnt_s < timing_s.active) && (vcnt_s < V_ACTIVE_C);
      hsync_n_s = !((hcnt_s >= timing_s.hs_start) && (hcnt_s < timing_s.hs_end));
      vsync_n_s = !((vcnt_s >= VS_START_C) && (vcnt_s < VS_END_C));
    end else begin
      disp_s    = 1'b0;
      hsync_n_s = 1'b1;
      vsync_n_s = 1'b1;
    end
  end

  // State, counter and registered-output update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      mode_r    <= RESO_B1;
      started_r <= 1'b0;
      hcnt_r    <= 10'd0;
      vcnt_r    <= 9'd0;
      hsync_n_r <= 1'b1;
      vsync_n_r <= 1'b1;
      disp_r    <= 1'b0;
      line_r    <= 1'b0;
      frame_r   <= 1'b0;
      vblank_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      mode_r    <= mode_s;
      started_r <= started_s;
      hcnt_r    <= hcnt_s;
      vcnt_r    <= vcnt_s;
      hsync_n_r <= hsync_n_s;
      vsync_n_r <= vsync_n_s;
      disp_r    <= disp_s;
      line_r    <= line_s;
      frame_r   <= frame_s;
      vblank_r  <= vblank_s;
    end
  end

  assign HCNT         = hcnt_r;
  assign VCNT         = vcnt_r;
  assign HSYNC_n      = hsync_n_r;
  assign VSYNC_n      = vsync_n_r;
  assign DISP_EN      = disp_r;
  assign LINE_START   = line_r;
  assign FRAME_START  = frame_r;
  assign VBLANK_START = vblank_r;

endmodule

// File: tb/tb_t9990_timing.sv
// Testbench for t9990_timing. The vertical geometry is shrunk through the
// parameters so whole frames fit in a short run; the horizontal tables are
// the fixed per-mode values.
module tb_t9990_timing;

  localparam int VT  = 24;
  localparam int VA  = 16;
  localparam int VSS = 19;
  localparam int VSW = 3;

  localparam logic [24:0] RST_VEC = {10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 3'b000};

  logic       CLK = 1'b0;
  logic       RESET;
  logic       DCLK_EN;
  logic       TG_EN;
  logic [2:0] RESO;
  logic [9:0] HCNT;
  logic [8:0] VCNT;
  logic       HSYNC_n;
  logic       VSYNC_n;
  logic       DISP_EN;
  logic       LINE_START;
  logic       FRAME_START;
  logic       VBLANK_START;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_h, m_v, m_mode;
  bit m_ls, m_fs, m_vb;

  int ht_tab  [4] = '{342, 455, 684, 910};
  int ha_tab  [4] = '{256, 384, 512, 768};
  int hss_tab [4] = '{270, 405, 540, 810};
  int hsw_tab [4] = '{25, 33, 50, 67};

  t9990_timing #(
    .V_TOTAL (VT),
    .V_ACTIVE(VA),
    .VS_START(VSS),
    .VS_WIDTH(VSW)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .DCLK_EN     (DCLK_EN),
    .TG_EN       (TG_EN),
    .RESO        (RESO),
    .HCNT        (HCNT),
    .VCNT        (VCNT),
    .HSYNC_n     (HSYNC_n),
    .VSYNC_n     (VSYNC_n),
    .DISP_EN     (DISP_EN),
    .LINE_START  (LINE_START),
    .FRAME_START (FRAME_START),
    .VBLANK_START(VBLANK_START)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // gap-1 idle clocks, then one clock with DCLK_EN high
  task automatic dot(input int gap);
    repeat (gap - 1) tick();
    DCLK_EN = 1'b1;
    tick();
    DCLK_EN = 1'b0;
  endtask

  task automatic model_first();
    m_h = 0; m_v = 0; m_ls = 1'b1; m_fs = 1'b1; m_vb = 1'b0;
  endtask

  task automatic model_adv();
    m_ls = 1'b0; m_fs = 1'b0; m_vb = 1'b0;
    if (m_h == ht_tab[m_mode] - 1) begin
      m_h  = 0;
      m_ls = 1'b1;
      if (m_v == VT - 1) begin
        m_v    = 0;
        m_fs   = 1'b1;
        m_mode = int'(RESO);
      end else begin
        m_v  = m_v + 1;
        m_vb = (m_v == VA);
      end
    end else begin
      m_h = m_h + 1;
    end
  endtask

  function automatic logic [24:0] exp_vec();
    logic hs, vs, de;
    de = (m_h < ha_tab[m_mode]) && (m_v < VA);
    hs = !((m_h >= hss_tab[m_mode]) && (m_h < hss_tab[m_mode] + hsw_tab[m_mode]));
    vs = !((m_v >= VSS) && (m_v < VSS + VSW));
    return {m_h[9:0], m_v[8:0], hs, vs, de, m_ls, m_fs, m_vb};
  endfunction

  function automatic logic [24:0] obs_vec();
    return {HCNT, VCNT, HSYNC_n, VSYNC_n, DISP_EN, LINE_START, FRAME_START, VBLANK_START};
  endfunction

  task automatic test_reset();
    RESET = 1'b1; TG_EN = 1'b0; DCLK_EN = 1'b0; RESO = 3'd0;
    tick(); tick();
    checks++;
    if (obs_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs_vec(), RST_VEC);
    end
    RESET = 1'b0;
  endtask

  task automatic test_b1_line();
    int hs_low = 0;
    int hs_first = -1;
    int de_cnt = 0;
    logic [24:0] e;
    RESO = 3'd0; TG_EN = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL b1_enter_run: got %h expected %h", obs_vec(), RST_VEC);
    end
    m_mode = 0;
    for (int i = 0; i < 343; i++) begin
      DCLK_EN = 1'b1;
      tick();
      DCLK_EN = 1'b0;
      if (i == 0) model_first(); else model_adv();
      e = exp_vec();
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL b1_line_dot%0d: got %h expected %h", i, obs_vec(), e);
      end
      if (i == 0) begin
        checks++;
        if ({FRAME_START, LINE_START, HCNT} !== {1'b1, 1'b1, 10'd0}) begin
          errors++;
          $display("FAIL b1_first_strobes: got %b%b/%0d expected 11/0", FRAME_START, LINE_START, HCNT);
        end
      end
      if (i < 342) begin
        if (!HSYNC_n) begin
          hs_low++;
          if (hs_first < 0) hs_first = i;
        end
        if (DISP_EN) de_cnt++;
      end
      tick();
      checks++;
      if (obs_vec() !== (e & ~25'h7)) begin
        errors++;
        $display("FAIL b1_line_gap%0d: got %h expected %h", i, obs_vec(), e & ~25'h7);
      end
      tick(); tick();
    end
    checks++;
    if (hs_low !== 25 || hs_first !== 270) begin
      errors++;
      $display("FAIL b1_hsync: got %0d dots from %0d expected 25 from 270", hs_low, hs_first);
    end
    checks++;
    if (de_cnt !== 256) begin
      errors++;
      $display("FAIL b1_disp_en: got %0d expected 256", de_cnt);
    end
    checks++;
    if ({HCNT, VCNT} !== {10'd0, 9'd1}) begin
      errors++;
      $display("FAIL b1_hwrap: got %0d/%0d expected 0/1", HCNT, VCNT);
    end
  endtask

  task automatic test_b1_frame();
    int vb_cnt = 0;
    int vb_line = -1;
    int vs_lines = 0;
    int fs_n = -1;
    for (int i = 1; i <= 342 * (VT - 1); i++) begin
      dot(1);
      model_adv();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b1_frame: got %h expected %h", obs_vec(), exp_vec());
      end
      if (VBLANK_START) begin
        vb_cnt++;
        vb_line = int'(VCNT);
      end
      if (LINE_START && !VSYNC_n) vs_lines++;
      if (FRAME_START && fs_n < 0) fs_n = i;
    end
    checks++;
    if (vb_cnt !== 1 || vb_line !== VA) begin
      errors++;
      $display("FAIL vblank: got %0d pulses at line %0d expected 1 at %0d", vb_cnt, vb_line, VA);
    end
    checks++;
    if (vs_lines !== VSW) begin
      errors++;
      $display("FAIL vsync_lines: got %0d expected %0d", vs_lines, VSW);
    end
    checks++;
    if (fs_n !== 342 * (VT - 1)) begin
      errors++;
      $display("FAIL frame_period: got %0d expected %0d", fs_n, 342 * (VT - 1));
    end
  endtask

  task automatic test_mode_switch();
    int hmax = 0;
    int hs_low = 0;
    int hs_first = -1;
    for (int i = 0; i < 342 * 10; i++) begin
      dot(1);
      model_adv();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mode_pre: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    RESO = 3'd3;
    for (int i = 0; i < 342 * (VT - 10); i++) begin
      dot(1);
      model_adv();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mode_old_frame: got %h expected %h", obs_vec(), exp_vec());
      end
      if (int'(HCNT) > hmax) hmax = int'(HCNT);
    end
    checks++;
    if (hmax !== 341 || {FRAME_START, HCNT, VCNT} !== {1'b1, 10'd0, 9'd0}) begin
      errors++;
      $display("FAIL mode_hold_b1: got max %0d fs %b expected 341 fs 1", hmax, FRAME_START);
    end
    for (int i = 0; i < 910 * 2; i++) begin
      dot(1);
      model_adv();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mode_b4: got %h expected %h", obs_vec(), exp_vec());
      end
      if (VCNT == 9'd0 && !HSYNC_n) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(HCNT);
      end
    end
    checks++;
    if (hs_low !== 67 || hs_first !== 810) begin
      errors++;
      $display("FAIL b4_hsync: got %0d dots from %0d expected 67 from 810", hs_low, hs_first);
    end
  endtask

  task automatic test_tg_drop();
    for (int i = 0; i < 123; i++) begin
      dot(1);
      model_adv();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL tg_pre: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({HCNT, VCNT} !== {10'd123, 9'd2}) begin
      errors++;
      $display("FAIL tg_pos: got %0d/%0d expected 123/2", HCNT, VCNT);
    end
    TG_EN = 1'b0; DCLK_EN = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL tg_drop: got %h expected %h", obs_vec(), RST_VEC);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_vec() !== RST_VEC) begin
        errors++;
        $display("FAIL tg_low_dclk: got %h expected %h", obs_vec(), RST_VEC);
      end
    end
    DCLK_EN = 1'b0; TG_EN = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL tg_restart_idle: got %h expected %h", obs_vec(), RST_VEC);
    end
    dot(1);
    m_mode = 3;
    model_first();
    checks++;
    if (obs_vec() !== exp_vec() || FRAME_START !== 1'b1) begin
      errors++;
      $display("FAIL tg_restart_first: got %h expected %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 810; i++) begin
      dot(1);
      model_adv();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL tg_restart_run: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({HCNT, HSYNC_n} !== {10'd810, 1'b0}) begin
      errors++;
      $display("FAIL tg_b4_hsync: got %0d/%b expected 810/0", HCNT, HSYNC_n);
    end
  endtask

  task automatic test_hold();
    TG_EN = 1'b0;
    tick();
    RESO = 3'd4; TG_EN = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL hold_entry: got %h expected %h", obs_vec(), RST_VEC);
    end
    DCLK_EN = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      tick();
      checks++;
      if (obs_vec() !== RST_VEC) begin
        errors++;
        $display("FAIL hold_idle%0d: got %h expected %h", i, obs_vec(), RST_VEC);
      end
    end
    DCLK_EN = 1'b0; RESO = 3'd2;
    tick();
    checks++;
    if (obs_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL hold_to_idle: got %h expected %h", obs_vec(), RST_VEC);
    end
    tick();
    checks++;
    if (obs_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL hold_idle_to_run: got %h expected %h", obs_vec(), RST_VEC);
    end
    dot(1);
    m_mode = 2;
    model_first();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL b3_first: got %h expected %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 684; i++) begin
      dot(1);
      model_adv();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b3_line: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({HCNT, VCNT, LINE_START} !== {10'd0, 9'd1, 1'b1}) begin
      errors++;
      $display("FAIL b3_wrap: got %0d/%0d/%b expected 0/1/1", HCNT, VCNT, LINE_START);
    end
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 100; i++) begin
      dot(1);
      model_adv();
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL rst_pre: got %h expected %h", obs_vec(), exp_vec());
    end
    DCLK_EN = 1'b1; RESET = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_midline: got %h expected %h", obs_vec(), RST_VEC);
    end
    RESET = 1'b0; DCLK_EN = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_rerun_idle: got %h expected %h", obs_vec(), RST_VEC);
    end
    dot(1);
    m_mode = 2;
    model_first();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_rerun_first: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_b1_line();
    test_b1_frame();
    test_mode_switch();
    test_tg_drop();
    test_hold();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
